// File: rtl/ldpc_fifo_fwft.sv
// First-word-fall-through stream FIFO: block-RAM storage, one prefetch register fed by
// the synchronous RAM read, and a registered output stage. Any depth >= 2.
module ldpc_fifo_fwft #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 2048,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int LW            = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  input  logic             i_flush,
  output logic [LW-1:0]    o_level,
  output logic             o_almost_full,
  output logic             o_almost_empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("ldpc_fifo_fwft: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("ldpc_fifo_fwft: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("ldpc_fifo_fwft: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends combinationally on valid, and valid/data hold until accepted.

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;
  logic [AW-1:0]    head, tail;
  logic [LW-1:0]    ram_count, ram_count_nxt;
  logic [LW-1:0]    level_q, level_nxt;
  logic             pf_valid, pf_valid_nxt;
  logic             out_valid_q, out_valid_nxt;
  logic [WIDTH-1:0] out_data_q;
  logic             in_ready_q;
  logic             afull_q, aempty_q;
  logic             wr_fire, rd_fire, out_load, ram_rd;

  always_comb begin
    wr_fire       = 1'b0;
    rd_fire       = 1'b0;
    out_load      = 1'b0;
    ram_rd        = 1'b0;
    level_nxt     = level_q;
    ram_count_nxt = ram_count;
    pf_valid_nxt  = pf_valid;
    out_valid_nxt = out_valid_q;
    if (i_flush) begin
      level_nxt     = '0;
      ram_count_nxt = '0;
      pf_valid_nxt  = 1'b0;
      out_valid_nxt = 1'b0;
    end else begin
      wr_fire  = i_in_valid & in_ready_q;
      rd_fire  = out_valid_q & i_out_ready;
      // The prefetch word moves to the output whenever the output is free or being read.
      out_load = pf_valid & (~out_valid_q | rd_fire);
      ram_rd   = (ram_count != '0) & (~pf_valid | out_load);
      case ({wr_fire, rd_fire})
        2'b10:   level_nxt = level_q + LW'(1);
        2'b01:   level_nxt = level_q - LW'(1);
        default: level_nxt = level_q;
      endcase
      ram_count_nxt = ram_count + LW'(wr_fire) - LW'(ram_rd);
      if (ram_rd)        pf_valid_nxt = 1'b1;
      else if (out_load) pf_valid_nxt = 1'b0;
      if (out_load)      out_valid_nxt = 1'b1;
      else if (rd_fire)  out_valid_nxt = 1'b0;
    end
  end

  // Storage and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge i_clock) begin
    if (wr_fire) mem[tail] <= i_in_data;
    if (ram_rd)  ram_q     <= mem[head];
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head        <= '0;
      tail        <= '0;
      ram_count   <= '0;
      level_q     <= '0;
      pf_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end else begin
      ram_count   <= ram_count_nxt;
      level_q     <= level_nxt;
      pf_valid    <= pf_valid_nxt;
      out_valid_q <= out_valid_nxt;
      in_ready_q  <= (level_nxt < LW'(DEPTH));
      afull_q     <= (level_nxt >= LW'(AFULL_THRESH));
      aempty_q    <= (level_nxt <= LW'(AEMPTY_THRESH));
      if (i_flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (wr_fire) tail <= (tail == AW'(DEPTH - 1)) ? '0 : tail + AW'(1);
        if (ram_rd)  head <= (head == AW'(DEPTH - 1)) ? '0 : head + AW'(1);
        if (out_load) out_data_q <= ram_q;
      end
    end
  end

  assign o_in_ready     = in_ready_q;
  assign o_out_valid    = out_valid_q;
  assign o_out_data     = out_data_q;
  assign o_level        = level_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;

endmodule

// File: tb/tb_ldpc_fifo_fwft.sv
// Bench for ldpc_fifo_fwft: queue-based reference model checked every cycle, plus
// directed literal checks for priming, fill/drain, streaming, flush and async reset.
module tb_ldpc_fifo_fwft;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int LW = $clog2(D + 1);

  logic          i_clock = 1'b0;
  logic          i_reset_n;
  logic [W-1:0]  i_in_data;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  o_out_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          i_flush;
  logic [LW-1:0] o_level;
  logic          o_almost_full;
  logic          o_almost_empty;

  ldpc_fifo_fwft #(
    .WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_in_data      (i_in_data),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .o_out_data     (o_out_data),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .i_flush        (i_flush),
    .o_level        (o_level),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clock = ~i_clock;

  // ---------------- reference model ----------------
  // Contents in order, each with the edge number at which it was written; a word is
  // visible at the head once two edges have passed since its write.
  logic [W-1:0] exp_q[$];
  int           wt_q[$];
  int           cyc      = 0;
  bit           ready_ok = 1'b0;
  int           n_written = 0;
  int           n_checks  = 0;
  int           n_pass    = 0;

  function automatic bit m_valid();
    return (exp_q.size() > 0) && (wt_q[0] <= cyc - 2);
  endfunction

  function automatic bit m_ready();
    return ready_ok && (exp_q.size() < D);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all();
    chk("level", int'(o_level), exp_q.size());
    chk("in_ready", int'(o_in_ready), int'(m_ready()));
    chk("out_valid", int'(o_out_valid), int'(m_valid()));
    if (m_valid()) chk("out_data", int'(o_out_data), int'(exp_q[0]));
    chk("almost_full", int'(o_almost_full), int'(exp_q.size() >= AF));
    chk("almost_empty", int'(o_almost_empty), int'(exp_q.size() <= AE));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs, advances the model on the rising edge,
  // and compares at the next falling edge.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    bit mv, mr;
    i_in_valid  = v;
    i_in_data   = d;
    i_out_ready = r;
    i_flush     = f;
    mv = m_valid();
    mr = m_ready();
    @(posedge i_clock);
    cyc++;
    if (f) begin
      exp_q.delete();
      wt_q.delete();
    end else begin
      if (mv && r) begin
        void'(exp_q.pop_front());
        void'(wt_q.pop_front());
      end
      if (mr && v) begin
        exp_q.push_back(d);
        wt_q.push_back(cyc);
        n_written++;
      end
    end
    ready_ok = 1'b1;
    @(negedge i_clock);
    check_all();
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      step(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
  endtask

  // ---------------- stimulus + directed checks ----------------
  initial begin
    int guard;
    int rb;
    i_reset_n   = 1'b1;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    i_flush     = 1'b0;
    #1 i_reset_n = 1'b0;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    chk("rst_in_ready", int'(o_in_ready), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_out_data", int'(o_out_data), 0);
    chk("rst_almost_empty", int'(o_almost_empty), 1);
    chk("rst_almost_full", int'(o_almost_full), 0);
    i_reset_n = 1'b1;
    check_all();
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ready_after_release", int'(o_in_ready), 1);

    // Priming latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("prime_e0_valid", int'(o_out_valid), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("prime_e1_valid", int'(o_out_valid), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("prime_e2_valid", int'(o_out_valid), 1);
    chk("prime_e2_data", int'(o_out_data), 'hA5);
    chk("prime_e2_level", int'(o_level), 1);
    drain();

    // Fill to full, hold off a sixth word, read at full with a write pending, drain
    for (int k = 1; k <= 5; k++) step(1'b1, W'(k), 1'b0, 1'b0);
    chk("full_level", int'(o_level), 5);
    chk("full_in_ready", int'(o_in_ready), 0);
    chk("full_almost_full", int'(o_almost_full), 1);
    step(1'b1, 8'd6, 1'b0, 1'b0);
    chk("full_held_level", int'(o_level), 5);
    chk("drain_data_1", int'(o_out_data), 1);
    step(1'b1, 8'd6, 1'b1, 1'b0);
    chk("full_rd_level", int'(o_level), 4);
    chk("full_rd_in_ready", int'(o_in_ready), 1);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("drain_data_%0d", k), int'(o_out_data), k);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", int'(o_out_valid), 0);
    chk("drained_level", int'(o_level), 0);

    // Streaming across the pointer wrap
    for (int j = 0; j < 22; j++) begin
      step(j < 20, W'(j), 1'b1, 1'b0);
      if (j >= 2) begin
        chk("stream_valid", int'(o_out_valid), 1);
        chk("stream_data", int'(o_out_data), j - 2);
      end
      if (j >= 2 && j <= 19) chk("stream_level", int'(o_level), 3);
    end
    drain();

    // Flush with a concurrent write
    for (int k = 0; k < 3; k++) step(1'b1, W'(8'h30 + k), 1'b0, 1'b0);
    chk("pre_flush_level", int'(o_level), 3);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("flush_level", int'(o_level), 0);
    chk("flush_valid", int'(o_out_valid), 0);
    chk("flush_in_ready", int'(o_in_ready), 1);
    chk("flush_almost_empty", int'(o_almost_empty), 1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    chk("post_flush_valid", int'(o_out_valid), 0);

    // Randomized traffic with back-pressure and occasional flush
    n_written = 0;
    guard = 0;
    while (n_written < 1000 && guard < 20000) begin
      rb = 1 + (guard / 250) % 3;
      step($urandom_range(0, 3) != 0, W'($urandom_range(0, 255)),
           $urandom_range(0, 3) < rb, $urandom_range(0, 299) == 0);
      guard++;
    end
    chk("random_words_done", int'(n_written >= 1000), 1);
    drain();

    // Asynchronous reset between edges
    for (int k = 0; k < 3; k++) step(1'b1, W'(8'h50 + k), 1'b0, 1'b0);
    chk("pre_reset_valid", int'(o_out_valid), 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(o_out_valid), 0);
    chk("async_rst_in_ready", int'(o_in_ready), 0);
    chk("async_rst_level", int'(o_level), 0);
    exp_q.delete();
    wt_q.delete();
    ready_ok   = 1'b0;
    i_in_valid = 1'b0;
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    check_all();
    for (int k = 0; k < 40; k++)
      step($urandom_range(0, 1) == 1, W'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ldpc_fifo_fwft.md
Name: ldpc_fifo_fwft

Overview:
Parametrised successor to the LDPC decoder's ready/valid stream FIFO. Block-RAM storage with a registered first-word-fall-through output stage, so the read path is synchronous and timing-clean. Adds non-power-of-two depth, an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. Sits between LLR/message producers and decoder cores wherever elastic buffering with back-pressure is needed.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 2048, total word capacity including the output stage; any integer >=2, not restricted to powers of two
AFULL_THRESH, DEPTH-4, o_almost_full asserts when occupancy >= this value; legal range 1..DEPTH
AEMPTY_THRESH, 4, o_almost_empty asserts when occupancy <= this value; legal range 0..DEPTH-1
LW, $clog2(DEPTH+1), derived width of the occupancy count; not overridden

Ports:
i_clock  in  1  single clock; all logic rising-edge
i_reset_n  in  1  asynchronous, active-low reset
i_in_data  in  WIDTH  write data
i_in_valid  in  1  write request
o_in_ready  out  1  FIFO can accept; a write happens when i_in_valid & o_in_ready at a rising edge
o_out_data  out  WIDTH  head-of-queue word, registered
o_out_valid  out  1  o_out_data holds a valid word
i_out_ready  in  1  consumer accepts; a read happens when o_out_valid & i_out_ready at a rising edge
i_flush  in  1  synchronous discard of all contents
o_level  out  LW  words currently held (RAM + output stage), 0..DEPTH
o_almost_full  out  1  registered, o_level >= AFULL_THRESH
o_almost_empty  out  1  registered, o_level <= AEMPTY_THRESH

Behaviour:
- Reset (i_reset_n low, asynchronous assert, synchronous release): head=tail=0, o_level=0, o_in_ready=0, o_out_valid=0, o_out_data=0, o_almost_full=0, o_almost_empty=1. o_in_ready rises on the first rising edge after release. Reset mid-operation discards all contents and takes effect immediately.
- All outputs are registered; no input-to-output combinational path.
- Storage: RAM with synchronous read, inferred as block RAM. Head/tail pointers wrap from DEPTH-1 (or the RAM's last index) to 0 by explicit compare, never by natural overflow.
- Write latency: write accepted at edge E into an empty FIFO -> o_out_valid=1 and o_out_data=that word after edge E+2. The word is never visible before that edge.
- Throughput: one write and one read per cycle, sustained indefinitely at any occupancy 1..DEPTH-1 with no bubbles on o_out_valid once primed.
- Output hold: while o_out_valid=1 and i_out_ready=0, o_out_data is stable. On a read, the next word, if one is held, appears on the following edge with o_out_valid remaining 1.
- Ordering: strict FIFO, no loss, no duplication.
- o_level: +1 on write only, -1 on read only, unchanged on both or neither. Updated on the same edge as the event and counts in-flight prefetch words.
- o_in_ready = (next o_level < DEPTH), registered. At o_level=DEPTH, a read with i_in_valid high does not write that cycle; o_in_ready returns to 1 the next cycle.
- Empty with i_out_ready=1: no read, o_out_valid stays 0, nothing underflows.
- Flags recompute from the next o_level on the same edge, so they are always consistent with o_level.
- i_flush=1 at edge E: after E, o_level=0, o_out_valid=0, o_in_ready=1, o_almost_empty=1, o_almost_full=0, and pointers reset. A write or read presented in the flush cycle is discarded. Flush has priority over all other events except reset.
- Illegal parameters (DEPTH<2, thresholds out of range) raise an elaboration-time error.

Test Plan:
- Reset/priming: hold i_reset_n low 3 cycles, release -> o_in_ready 0 then 1 one edge later; o_level=0, o_almost_empty=1. Write 0xA5 at edge E -> o_out_valid=1, o_out_data=0xA5 after edge E+2, o_level=1.
- Fill to full, DEPTH=5 (non-power-of-two), i_out_ready=0: write 1..5 -> o_in_ready=0 after 5th write, o_level=5, o_almost_full=1 (AFULL_THRESH=4). A 6th word is held off. Drain all -> output 1,2,3,4,5 in order, then o_out_valid=0.
- Streaming wrap: DEPTH=5, continuous write/read with both valid and ready high for 20 words (values 0..19) -> output 0..19 in order with no gaps after priming; o_level constant.
- Back-pressure: random i_out_ready toggling while o_out_valid=1 -> o_out_data never changes while ready is low; scoreboard matches 1000 random words.
- Simultaneous at full: o_level=DEPTH, i_in_valid=1, i_out_ready=1 -> one read, no write; next cycle o_level=DEPTH-1, o_in_ready=1.
- Flush and async reset: with o_level=3, pulse i_flush together with a write -> o_level=0, o_out_valid=0, the written word is never output. Assert i_reset_n low mid-stream, between edges -> o_out_valid and o_in_ready drop immediately, without waiting for a clock edge.
